// File: rtl/apb_pkg.sv
// Shared types and widths for the APB completer memory.
// Addresses are zero-extended to APB_ADDR_W before range checks so a 256-entry depth compares cleanly.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_RESP = 3'b100
  } state_e;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Flop-based register memory: async clear, one synchronous write port, one combinational read port.
// Out-of-range addresses read as zero and never write.
module apb_slave_mem_array
  import apb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic          wInRange;
  logic          rInRange;

  assign wInRange = APB_ADDR_W'(waddr_i) < APB_ADDR_W'(DEPTH);
  assign rInRange = APB_ADDR_W'(raddr_i) < APB_ADDR_W'(DEPTH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && wInRange) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = rInRange ? mem_q[raddr_i[IW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with programmable wait states and a byte-wide register memory.
// Writes commit on the completing ENABLE edge; PSLVERR flags range, read-only and no-setup accesses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int RO_BASE     = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic [2:0]            check_state
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  setupErr;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memRaddr;
  logic [DATA_WIDTH-1:0] memRdata;

  assign setupErr = (APB_ADDR_W'(PADDR) >= APB_ADDR_W'(MEM_DEPTH)) ||
                    (PWRITE && (APB_ADDR_W'(PADDR) >= APB_ADDR_W'(RO_BASE)));

  // A transfer entering RESP straight from IDLE must read with the live PADDR, not the latched one.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    memWe    = 1'b0;
    memRaddr = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (PSEL) begin
          addr_d   = PADDR;
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          memRaddr = PADDR;
          cnt_d    = 4'(WAIT_STATES);
          if (!PENABLE) begin
            err_d   = setupErr;
            state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        memWe   = PSEL && PENABLE && write_q && !err_q;
      end
      default: state_d = ST_IDLE;
    endcase

    pready_d = (state_d == ST_RESP);
    prdata_d = (state_d == ST_RESP && !write_d && !err_d) ? memRdata : '0;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  apb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH)
  ) uArray (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (memWe),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (memRaddr),
    .rdata_o (memRdata)
  );

  assign PREADY      = pready_q;
  assign PRDATA      = prdata_q;
  assign PSLVERR     = pready_q & err_q;
  assign check_state = state_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (A: no waits, RO from 0xF0; B: 3 waits, 128 deep)
// sharing a bus with separate selects, like the two slaves behind the bridge.
module tb_apb_slave_mem;

  logic       PCLK = 1'b0;
  logic       rstA, rstB, pselA, pselB, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       readyA, readyB, errA, errB;
  logic [7:0] rdataA, rdataB;
  logic [2:0] stateA, stateB;

  int nVec = 0;
  int nMis = 0;

  logic [7:0] modelMem [2][256];

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.MEM_DEPTH(256), .RO_BASE(8'hF0), .WAIT_STATES(0)) dutA (
    .PCLK(PCLK), .PRESET(rstA), .PSEL(pselA), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(readyA), .PRDATA(rdataA),
    .PSLVERR(errA), .check_state(stateA));

  apb_slave_mem #(.MEM_DEPTH(128), .RO_BASE(256), .WAIT_STATES(3)) dutB (
    .PCLK(PCLK), .PRESET(rstB), .PSEL(pselB), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(readyB), .PRDATA(rdataB),
    .PSLVERR(errB), .check_state(stateB));

  function automatic int wsOf(int inst);    return (inst != 0) ? 3 : 0;       endfunction
  function automatic int depthOf(int inst); return (inst != 0) ? 128 : 256;   endfunction
  function automatic int roOf(int inst);    return (inst != 0) ? 256 : 'hF0;  endfunction

  function automatic logic rdy(int inst);        return (inst != 0) ? readyB : readyA; endfunction
  function automatic logic slvErr(int inst);     return (inst != 0) ? errB : errA;     endfunction
  function automatic logic [7:0] rdOf(int inst); return (inst != 0) ? rdataB : rdataA; endfunction
  function automatic logic [2:0] stOf(int inst); return (inst != 0) ? stateB : stateA; endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setSel(input int inst, input logic v);
    if (inst != 0) pselB = v;
    else           pselA = v;
  endtask

  // Starts at a falling edge with the setup phase, ends at a falling edge with the bus idle.
  task automatic applyStimulus(input int inst, input bit wr, input logic [7:0] addr,
                               input logic [7:0] data, input logic [7:0] expData, input bit expErr);
    int    waits;
    string tag;
    tag = $sformatf("%s%0d@%02h", wr ? "wr" : "rd", inst, addr);
    setSel(inst, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(negedge PCLK);
    penable = 1'b1;
    waits = 0;
    while (!rdy(inst) && waits < 20) begin
      @(negedge PCLK);
      waits++;
    end
    checkOutput({tag, " waits"},   32'(waits), 32'(wsOf(inst)));
    checkOutput({tag, " pready"},  32'(rdy(inst)), 32'd1);
    checkOutput({tag, " pslverr"}, 32'(slvErr(inst)), 32'(expErr));
    checkOutput({tag, " prdata"},  32'(rdOf(inst)), wr ? 32'd0 : 32'(expData));
    @(negedge PCLK);
    checkOutput({tag, " idleState"},  32'(stOf(inst)), 32'h1);
    checkOutput({tag, " idlePrdata"}, 32'(rdOf(inst)), 32'd0);
    setSel(inst, 1'b0);
    penable = 1'b0;
  endtask

  task automatic modelTransfer(input int inst, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    bit         expErr;
    logic [7:0] expData;
    expErr  = (int'(addr) >= depthOf(inst)) || (wr && int'(addr) >= roOf(inst));
    expData = (!wr && !expErr) ? modelMem[inst][addr] : 8'h00;
    applyStimulus(inst, wr, addr, data, expData, expErr);
    if (wr && !expErr) modelMem[inst][addr] = data;
  endtask

  typedef struct {
    int         inst;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] expData;
    bit         expErr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{1, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    vecs[3]  = '{1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[4]  = '{1, 1'b1, 8'h90, 8'h3C, 8'h00, 1'b1};
    vecs[5]  = '{1, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{0, 1'b1, 8'hF4, 8'h11, 8'h00, 1'b1};
    vecs[7]  = '{0, 1'b0, 8'hF4, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{0, 1'b1, 8'hEF, 8'h5A, 8'h00, 1'b0};
    vecs[9]  = '{0, 1'b0, 8'hEF, 8'h00, 8'h5A, 1'b0};
    vecs[10] = '{1, 1'b1, 8'h7F, 8'hC3, 8'h00, 1'b0};
    vecs[11] = '{1, 1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0};
    vecs[12] = '{0, 1'b1, 8'hF0, 8'h99, 8'h00, 1'b1};
    vecs[13] = '{1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1};

    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++)
        modelMem[i][a] = 8'h00;

    rstA = 1'b1; rstB = 1'b1;
    pselA = 1'b0; pselB = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    repeat (2) @(negedge PCLK);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset%0d state", i),   32'(stOf(i)), 32'h1);
      checkOutput($sformatf("reset%0d pready", i),  32'(rdy(i)), 32'd0);
      checkOutput($sformatf("reset%0d pslverr", i), 32'(slvErr(i)), 32'd0);
      checkOutput($sformatf("reset%0d prdata", i),  32'(rdOf(i)), 32'd0);
    end
    rstA = 1'b0; rstB = 1'b0;
    @(negedge PCLK);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].expData, vecs[i].expErr);
      if (vecs[i].wr && !vecs[i].expErr) modelMem[vecs[i].inst][vecs[i].addr] = vecs[i].data;
    end

    // ENABLE without a preceding setup phase.
    pselA = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h30; pwdata = 8'hEE;
    @(negedge PCLK);
    checkOutput("nosetup pready",  32'(readyA), 32'd1);
    checkOutput("nosetup pslverr", 32'(errA), 32'd1);
    @(negedge PCLK);
    pselA = 1'b0; penable = 1'b0;
    modelTransfer(0, 1'b0, 8'h30, 8'h00);

    // Reset pulse in the middle of a waited write.
    pselB = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h77;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    checkOutput("midwait state",  32'(stateB), 32'h2);
    checkOutput("midwait pready", 32'(readyB), 32'd0);
    rstB = 1'b1;
    #1;
    checkOutput("midrst state",   32'(stateB), 32'h1);
    checkOutput("midrst pready",  32'(readyB), 32'd0);
    checkOutput("midrst pslverr", 32'(errB), 32'd0);
    checkOutput("midrst prdata",  32'(rdataB), 32'd0);
    for (int a = 0; a < 256; a++) modelMem[1][a] = 8'h00;
    pselB = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    rstB = 1'b0;
    @(negedge PCLK);
    modelTransfer(1, 1'b0, 8'h20, 8'h00);

    // Randomized back-to-back traffic, biased towards the range and read-only boundaries.
    for (int n = 0; n < 80; n++) begin
      int         inst;
      bit         wr;
      logic [7:0] addr;
      int         sel;
      inst = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 2));
      if (sel == 0)      addr = 8'($urandom_range(0, 255));
      else if (sel == 1) addr = 8'($urandom_range('h78, 'h87));
      else               addr = 8'($urandom_range('hE8, 'hF7));
      if ($urandom_range(0, 3) == 0) @(negedge PCLK);
      modelTransfer(inst, wr, addr, 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
